// File: rtl/uart_rx_param_if.sv
// Receive-side sink interface of uart_rx_param.
// Handshake: the receiver (master) holds data_out_valid high while its FIFO is
// non-empty and data_out/frame_err/parity_err describe the head entry; the
// sink (slave) raises data_out_ready to accept it, and an entry is consumed on
// every rising clock edge where data_out_valid and data_out_ready are both 1.
// fsm_state is a debug view of the receiver state machine.
interface uart_rx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    logic [DATA_BITS-1:0]          data_out;
    logic                          data_out_valid;
    logic                          data_out_ready;
    logic                          frame_err;
    logic                          parity_err;
    logic                          overrun;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [2:0]                    fsm_state;

    modport master (
        output data_out, data_out_valid, frame_err, parity_err, overrun, fifo_count, fsm_state,
        input  data_out_ready
    );

    modport slave (
        input  data_out, data_out_valid, frame_err, parity_err, overrun, fifo_count, fsm_state,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-rejecting start
// detection, mid-bit sampling, per-character frame/parity flags and a
// first-word-fall-through receive FIFO with overrun reporting.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit between the
// data and stop bits; without it parity_err is tied to 0).
module uart_rx_param #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    uart_rx_param_if.master  rx_if
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int TW = $clog2(SYMBOL_EDGE_TIME);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
    localparam int EW = DATA_BITS + 2;
`else
    localparam int EW = DATA_BITS + 1;
`endif
    localparam logic [TW-1:0] SAMPLE_PT = TW'(SAMPLE_TIME - 1);
    localparam logic [TW-1:0] LAST_T    = TW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    // Reject illegal configurations at elaboration time.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SYMBOL_EDGE_TIME < 4) begin : g_bad_baud
        $error("uart_rx_param: need at least 4 clocks per bit");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [1:0]           sync_q, sync_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        entry_d, head;
    logic                 rx_s, sample, push, pop, do_push, empty, full;

    // Frame state machine: timing, bit sampling and character assembly.
    always_comb begin
        sync_d    = {sync_q[0], serial_in};
        rx_s      = sync_q[1];
        sample    = (timer_q == SAMPLE_PT);
        state_d   = state_q;
        timer_d   = (timer_q == LAST_T) ? '0 : timer_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        // Line went back high before mid-bit: a glitch.
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d    = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    perr_d  = ((^shift_q) ^ rx_s) != PARITY_ODD[0];
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    if (!rx_s) ferr_d = 1'b1;
                    if (bit_cnt_q == LAST_STOP) begin
                        // Leave at mid-stop so a back-to-back start is caught.
                        push      = 1'b1;
                        state_d   = IDLE;
                        timer_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_RX_PARITY_EN
        entry_d = {perr_q, ferr_d, shift_q};
`else
        entry_d = {ferr_d, shift_q};
`endif
    end

    // FIFO bookkeeping: pop on handshake, push unless full without a pop.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        pop       = !empty && rx_if.data_out_ready;
        do_push   = push && (!full || pop);
        overrun_d = push && full && !pop;
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
        head      = mem_q[rd_ptr_q];
    end

    // State, timer, synchroniser and FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; occupancy is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_d;
    end

    // Head entry is gated by valid so outputs read 0 while empty.
    always_comb begin
        rx_if.data_out_valid = !empty;
        rx_if.data_out       = empty ? '0 : head[DATA_BITS-1:0];
        rx_if.frame_err      = !empty && head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
        rx_if.parity_err     = !empty && head[DATA_BITS+1];
`else
        rx_if.parity_err     = 1'b0;
`endif
        rx_if.overrun        = overrun_q;
        rx_if.fifo_count     = count_q;
        rx_if.fsm_state      = state_q;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with configurable frame format, glitch-rejecting start detection, per-character error flags and a first-word-fall-through receive FIFO. Sits between the `serial_in` pad and the CPU-side MMIO/sink logic. Absorbs back-pressure up to `FIFO_DEPTH` characters and reports overrun when the FIFO cannot accept a character.

## Interface
- `CLOCK_FREQ`, 125_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s; `SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE`; `SAMPLE_TIME = SYMBOL_EDGE_TIME/2`.
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `STOP_BITS`, 1: stop bits, legal 1 or 2.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥2.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `serial_in` input 1: asynchronous serial line, idle high.
- `data_out` output DATA_BITS: head-of-FIFO character.
- `data_out_valid` output 1: FIFO not empty.
- `data_out_ready` input 1: sink accepts head entry when high with `data_out_valid`.
- `frame_err` output 1: head entry had a low stop bit.
- `parity_err` output 1: head entry failed parity; constant 0 without `UART_RX_PARITY_EN`.
- `overrun` output 1: one-cycle pulse when a completed character is dropped.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: occupied entries.

## Operation
- `serial_in` passes a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- Bit timer counts 0..SYMBOL_EDGE_TIME-1, reset on entering START. A bit is sampled when the timer equals SAMPLE_TIME-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on `rx_s` = 0.
  - START: at sample point, `rx_s` = 1 -> IDLE as a false start, no push; `rx_s` = 0 -> DATA.
  - DATA: samples DATA_BITS bits into a shift register, LSB first, then goes to PARITY if compiled in, else to STOP.
  - PARITY: samples one bit; error if XOR(data, parity bit) ≠ PARITY_ODD.
  - STOP: samples STOP_BITS bits; any low stop sample sets the entry's frame error. After the final stop sample, the character is pushed and the FSM returns to IDLE in the same cycle, without waiting for the bit end. This allows resynchronisation to a back-to-back start bit.
- Entry pushed into the FIFO: {parity_err, frame_err, data}. Characters with errors are still pushed.
- Break (all zeros plus low stop) is pushed as data 0 with `frame_err`=1.
- FIFO behaviour:
  - Pop when `data_out_valid & data_out_ready`.
  - Push while full without a same-cycle pop: character dropped, `overrun` pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while not empty: count unchanged.
- `data_out_ready` high while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH; count saturates at neither end by construction.

## Timing
- Reset values: `data_out_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `fifo_count`=0, `data_out`=0, FSM=IDLE, timer=0.
- Reset asserted mid-frame aborts the frame with no push; FIFO is emptied.
- Latency from `serial_in` edge to `rx_s`: 2 cycles.
- Push happens at the clock edge following the final stop sample. `data_out_valid` and `fifo_count` update that edge.
- FWFT: `data_out`, `frame_err` and `parity_err` are valid whenever `data_out_valid`=1 and are combinationally tied to the head entry.
- After a pop, the next entry is presented in the same cycle that count decrements.
- `overrun` is high for exactly the one cycle after the dropped push.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, and one parity bit is expected between the data and stop bits. `parity_err` reports mismatches against `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined: no PARITY state, the frame is start+data+stop, the parity_err FIFO bit is removed, and `parity_err` is tied to 0. `PARITY_ODD` is ignored.

## Test plan
All cases use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (10 cycles/bit) unless noted.
- 8N1, byte 0xA5, ready=1 -> `data_out`=0xA5, `frame_err`=0, valid for 1 cycle, `fifo_count` 1->0.
- 8N1, 0x3C with stop bit driven low -> entry 0x3C, `frame_err`=1. Next frame 0x5A, sent immediately after, is received correctly.
- 4-cycle low glitch on idle line -> no push, FSM back to IDLE, `fifo_count` stays 0.
- FIFO_DEPTH=4, ready=0, send 0x01..0x05 -> `fifo_count`=4, `overrun` pulses once on the 5th character. Draining yields 0x01..0x04 in order.
- With `UART_RX_PARITY_EN`, PARITY_ODD=0: send 0x07 with parity 1 -> `parity_err`=0. Send 0x07 with parity 0 -> `parity_err`=1.
- DATA_BITS=7, STOP_BITS=2, back-to-back frames 0x7F, 0x00 -> both received. Assert `rst` mid-third frame -> `fifo_count`=0, all outputs at reset values.
